mole_scheduler: RTL and testbench

MOLE_SCHEDULER -- requirements
Module: mole_scheduler

---
 rtl/mole_pkg.sv | 36 +++
 rtl/mole_lfsr.sv | 24 ++
 rtl/mole_scheduler.sv | 146 ++++++++++++++
 tb/tb_mole_scheduler.sv | 486 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mole_pkg.sv
// Shared types and constants for the mole scheduler and its LFSR.
package mole_pkg;

    localparam int NUM_HOLES = 5;
    localparam int LIFE_W    = 4;

    // Fibonacci taps 8,6,5,4 as a mask over state bits [7:0]
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    // hitIndex encoding: FIRST..LAST select hole 0..NUM_HOLES-1, anything else is no target
    localparam logic [2:0] HIT_IDX_FIRST = 3'd1;
    localparam logic [2:0] HIT_IDX_LAST  = 3'd5;

    typedef enum logic [1:0] {
        HOLE_EMPTY    = 2'd0,
        HOLE_UP       = 2'd1,
        HOLE_COOLDOWN = 2'd2
    } hole_state_t;

    // Candidate hole from the low LFSR bits; 5/6/7 fold back onto holes 0/1/2
    function automatic logic [2:0] lfsr_to_hole(input logic [7:0] state);
        logic [2:0] low;
        low = state[2:0];
        return (low >= 3'(NUM_HOLES)) ? low - 3'(NUM_HOLES) : low;
    endfunction

    function automatic logic [2:0] count_ones(input logic [NUM_HOLES-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used to pick spawn candidates.
module mole_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    output logic [7:0] state
);
    import mole_pkg::*;

    logic feedback;

    assign feedback = ^(state & LFSR_TAPS);

    // Shift left every clock, feedback into bit 0; SEED must be non-zero
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= SEED;
        end else begin
            state <= {state[6:0], feedback};
        end
    end

endmodule

// File: rtl/mole_scheduler.sv
// Mole scheduler: spawns moles on enabled ticks, ages them, and resolves
// player hit edges into hit/miss strobes and expiries into escape strobes.
//
// hole state    | meaning
// HOLE_EMPTY    | nothing raised, eligible for spawn
// HOLE_UP       | mole raised, life holds remaining ticks
// HOLE_COOLDOWN | mole just escaped, held out for one enabled tick
module mole_scheduler #(
    parameter int         NUM_HOLES = 5,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear,
    input  logic                 tick,
    input  logic                 hitValid,
    input  logic [2:0]           hitIndex,
    input  logic [2:0]           maxUp,
    input  logic [3:0]           upTime,
    output logic [NUM_HOLES-1:0] molesUp,
    output logic [2:0]           activeCount,
    output logic                 hitPulse,
    output logic                 missPulse,
    output logic                 escapePulse
);
    import mole_pkg::*;

    hole_state_t          state_q [NUM_HOLES];
    hole_state_t          state_d [NUM_HOLES];
    logic [LIFE_W-1:0]    life_q  [NUM_HOLES];
    logic [LIFE_W-1:0]    life_d  [NUM_HOLES];
    logic [7:0]           lfsr_state;
    logic                 hit_prev;
    logic                 hit_event;
    logic                 hit_in_range;
    logic [2:0]           hit_target;
    logic [2:0]           spawn_hole;
    logic [LIFE_W-1:0]    spawn_life;
    logic [NUM_HOLES-1:0] expired;
    logic [NUM_HOLES-1:0] up_d;
    logic                 hit_d;
    logic                 miss_d;
    logic                 escape_d;

    mole_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clock (clock),
        .reset (reset),
        .state (lfsr_state)
    );

    assign hit_event    = hitValid & ~hit_prev;
    assign hit_in_range = (hitIndex >= HIT_IDX_FIRST) && (hitIndex <= HIT_IDX_LAST);
    assign hit_target   = hitIndex - HIT_IDX_FIRST;
    assign spawn_hole   = lfsr_to_hole(lfsr_state);
    assign spawn_life   = (upTime == '0) ? LIFE_W'(1) : upTime;

    // Next hole states and event strobes; all decisions use the pre-edge state
    // so a hole leaving cooldown cannot respawn and a hit overrides an expiry.
    always_comb begin
        for (int i = 0; i < NUM_HOLES; i++) begin
            state_d[i] = state_q[i];
            life_d[i]  = life_q[i];
        end
        expired  = '0;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        escape_d = 1'b0;

        if (clear) begin
            for (int i = 0; i < NUM_HOLES; i++) begin
                state_d[i] = HOLE_EMPTY;
                life_d[i]  = '0;
            end
        end else if (enable) begin
            if (tick) begin
                for (int i = 0; i < NUM_HOLES; i++) begin
                    case (state_q[i])
                        HOLE_UP: begin
                            if (life_q[i] <= LIFE_W'(1)) begin
                                state_d[i] = HOLE_COOLDOWN;
                                life_d[i]  = '0;
                                expired[i] = 1'b1;
                            end else begin
                                life_d[i] = life_q[i] - LIFE_W'(1);
                            end
                        end
                        HOLE_COOLDOWN: state_d[i] = HOLE_EMPTY;
                        default:       state_d[i] = state_q[i];
                    endcase
                end
                if ((state_q[spawn_hole] == HOLE_EMPTY) && (activeCount < maxUp)) begin
                    state_d[spawn_hole] = HOLE_UP;
                    life_d[spawn_hole]  = spawn_life;
                end
            end

            if (hit_event && hit_in_range) begin
                if (state_q[hit_target] == HOLE_UP) begin
                    state_d[hit_target] = HOLE_EMPTY;
                    life_d[hit_target]  = '0;
                    expired[hit_target] = 1'b0;
                    hit_d               = 1'b1;
                end else begin
                    miss_d = 1'b1;
                end
            end

            escape_d = |expired;
        end

        for (int i = 0; i < NUM_HOLES; i++) begin
            up_d[i] = (state_d[i] == HOLE_UP);
        end
    end

    // Register hole state, edge history and every output
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_HOLES; i++) begin
                state_q[i] <= HOLE_EMPTY;
                life_q[i]  <= '0;
            end
            hit_prev    <= 1'b0;
            molesUp     <= '0;
            activeCount <= '0;
            hitPulse    <= 1'b0;
            missPulse   <= 1'b0;
            escapePulse <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_HOLES; i++) begin
                state_q[i] <= state_d[i];
                life_q[i]  <= life_d[i];
            end
            hit_prev    <= hitValid;
            molesUp     <= up_d;
            activeCount <= count_ones(up_d);
            hitPulse    <= hit_d;
            missPulse   <= miss_d;
            escapePulse <= escape_d;
        end
    end

endmodule

// File: tb/tb_mole_scheduler.sv
// Self-checking bench for mole_scheduler against a behavioural game model.
module tb_mole_scheduler;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       clear;
    logic       tick;
    logic       hitValid;
    logic [2:0] hitIndex;
    logic [2:0] maxUp;
    logic [3:0] upTime;
    logic [4:0] molesUp;
    logic [2:0] activeCount;
    logic       hitPulse;
    logic       missPulse;
    logic       escapePulse;

    int n_total = 0;
    int n_bad   = 0;

    mole_scheduler #(
        .NUM_HOLES (5),
        .LFSR_SEED (8'hA5)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .clear       (clear),
        .tick        (tick),
        .hitValid    (hitValid),
        .hitIndex    (hitIndex),
        .maxUp       (maxUp),
        .upTime      (upTime),
        .molesUp     (molesUp),
        .activeCount (activeCount),
        .hitPulse    (hitPulse),
        .missPulse   (missPulse),
        .escapePulse (escapePulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    localparam int K_EMPTY = 0;
    localparam int K_UP    = 1;
    localparam int K_COOL  = 2;

    int m_lfsr;
    int m_kind [5];
    int m_life [5];
    bit m_prev;
    int e_moles;
    int e_count;
    bit e_hit;
    bit e_miss;
    bit e_esc;

    function automatic int next_lfsr(input int v);
        int fb;
        fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
        return ((v << 1) & 255) | fb;
    endfunction

    function automatic int cand_of(input int v);
        int c;
        c = v % 8;
        return (c >= 5) ? c - 5 : c;
    endfunction

    task automatic model_reset();
        m_lfsr = 8'hA5;
        m_prev = 1'b0;
        for (int i = 0; i < 5; i++) begin
            m_kind[i] = K_EMPTY;
            m_life[i] = 0;
        end
        e_moles = 0; e_count = 0; e_hit = 0; e_miss = 0; e_esc = 0;
    endtask

    task automatic model_step();
        int old_kind [5];
        bit escaped [5];
        int ups;
        int c;
        int h;
        old_kind = m_kind;
        ups = 0;
        for (int i = 0; i < 5; i++) begin
            if (old_kind[i] == K_UP) ups++;
            escaped[i] = 1'b0;
        end
        e_hit = 0; e_miss = 0; e_esc = 0;
        if (clear) begin
            for (int i = 0; i < 5; i++) begin
                m_kind[i] = K_EMPTY;
                m_life[i] = 0;
            end
        end else if (enable) begin
            if (tick) begin
                for (int i = 0; i < 5; i++) begin
                    if (old_kind[i] == K_UP) begin
                        if (m_life[i] <= 1) begin
                            m_kind[i] = K_COOL; m_life[i] = 0; escaped[i] = 1'b1;
                        end else begin
                            m_life[i] = m_life[i] - 1;
                        end
                    end else if (old_kind[i] == K_COOL) begin
                        m_kind[i] = K_EMPTY;
                    end
                end
                c = cand_of(m_lfsr);
                if (old_kind[c] == K_EMPTY && ups < int'(maxUp)) begin
                    m_kind[c] = K_UP;
                    m_life[c] = (upTime == 0) ? 1 : int'(upTime);
                end
            end
            if (hitValid && !m_prev && hitIndex >= 1 && hitIndex <= 5) begin
                h = int'(hitIndex) - 1;
                if (old_kind[h] == K_UP) begin
                    m_kind[h] = K_EMPTY; m_life[h] = 0; escaped[h] = 1'b0; e_hit = 1;
                end else begin
                    e_miss = 1;
                end
            end
            for (int i = 0; i < 5; i++) if (escaped[i]) e_esc = 1;
        end
        m_prev = hitValid;
        m_lfsr = next_lfsr(m_lfsr);
        e_moles = 0; e_count = 0;
        for (int i = 0; i < 5; i++) begin
            if (m_kind[i] == K_UP) begin
                e_moles = e_moles | (1 << i);
                e_count++;
            end
        end
    endtask

    function automatic logic [10:0] exp_vec();
        return {5'(e_moles), 3'(e_count), e_hit, e_miss, e_esc};
    endfunction

    function automatic logic [10:0] got_vec();
        return {molesUp, activeCount, hitPulse, missPulse, escapePulse};
    endfunction

    // Advance model and DUT by one clock; outputs are stable on return
    task automatic step();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    // Idle until the model's spawn candidate equals h, then tick once
    task automatic tick_for(input int h, input bit with_hit);
        int guard;
        guard = 0;
        tick = 1'b0;
        while (cand_of(m_lfsr) != h && guard < 300) begin
            step();
            guard++;
        end
        n_total++;
        if (guard >= 300) begin
            n_bad++;
            $display("FAIL tick_for_bound hole=%0d waited=%0d limit=300", h, guard);
        end
        tick = 1'b1;
        if (with_hit) begin
            hitValid = 1'b1;
            hitIndex = 3'(h + 1);
        end
        step();
        tick = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        enable = 0; clear = 0; tick = 0; hitValid = 0; hitIndex = 0; maxUp = 0; upTime = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        n_total++;
        if (got_vec() !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got=%b exp=%b", got_vec(), 11'd0);
        end
        reset = 1'b0;
    endtask

    task automatic test_first_spawn();
        enable = 1; maxUp = 5; upTime = 3;
        for (int k = 0; k < 16; k++) begin
            tick = (k % 4 == 0);
            step();
            if (k == 0) begin
                n_total++;
                if (molesUp !== 5'b00001 || activeCount !== 3'd1) begin
                    n_bad++;
                    $display("FAIL first_spawn got moles=%b cnt=%0d exp moles=00001 cnt=1", molesUp, activeCount);
                end
            end
            n_total++;
            if (got_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL first_spawn_model cyc=%0d got=%b exp=%b", k, got_vec(), exp_vec());
            end
        end
        tick = 0;
    endtask

    task automatic test_escape();
        hitValid = 0;
        do_clear();
        enable = 1; maxUp = 1; upTime = 3;
        tick_for(2, 0);
        maxUp = 0;
        for (int k = 1; k <= 3; k++) begin
            tick = 1; step(); tick = 0;
            n_total++;
            if (got_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL escape_model tick=%0d got=%b exp=%b", k, got_vec(), exp_vec());
            end
            step();
        end
        // outputs already moved one step past the 3rd tick; check held regs and model
        n_total++;
        if (molesUp[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL escape_hole_down got=%b exp=0", molesUp[2]);
        end
        tick = 1; step(); tick = 0;
        n_total++;
        if (molesUp !== 5'b00000 || escapePulse !== 1'b0) begin
            n_bad++;
            $display("FAIL escape_cooldown got moles=%b esc=%b exp 00000/0", molesUp, escapePulse);
        end
        maxUp = 1;
        tick_for(2, 0);
        n_total++;
        if (molesUp[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL escape_respawn got=%b exp=1", molesUp[2]);
        end
    endtask

    task automatic test_escape_pulse();
        hitValid = 0;
        do_clear();
        enable = 1; maxUp = 1; upTime = 3;
        tick_for(2, 0);
        maxUp = 0;
        repeat (2) begin
            tick = 1; step(); tick = 0;
        end
        tick = 1; step(); tick = 0;
        n_total++;
        if (escapePulse !== 1'b1 || molesUp[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL escape_pulse got esc=%b hole2=%b exp 1/0", escapePulse, molesUp[2]);
        end
        step();
        n_total++;
        if (escapePulse !== 1'b0) begin
            n_bad++;
            $display("FAIL escape_pulse_width got=%b exp=0", escapePulse);
        end
    endtask

    task automatic test_hit_hold();
        int hits;
        hitValid = 0;
        do_clear();
        enable = 1; maxUp = 1; upTime = 15;
        tick_for(3, 0);
        maxUp = 0;
        hitIndex = 3'd4;
        hitValid = 1;
        hits = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (hitPulse === 1'b1) hits++;
            n_total++;
            if (got_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL hit_hold_model cyc=%0d got=%b exp=%b", k, got_vec(), exp_vec());
            end
        end
        n_total++;
        if (hits != 1 || molesUp[3] !== 1'b0) begin
            n_bad++;
            $display("FAIL hit_hold got hits=%0d hole3=%b exp 1/0", hits, molesUp[3]);
        end
        hitValid = 0; step();
        hitValid = 1; step();
        n_total++;
        if (missPulse !== 1'b1 || hitPulse !== 1'b0) begin
            n_bad++;
            $display("FAIL hit_then_miss got miss=%b hit=%b exp 1/0", missPulse, hitPulse);
        end
        hitValid = 0;
        hitIndex = 3'd6; step(); hitValid = 1; step();
        n_total++;
        if (got_vec() !== exp_vec() || missPulse !== 1'b0) begin
            n_bad++;
            $display("FAIL hit_bad_index got=%b exp=%b", got_vec(), exp_vec());
        end
        hitValid = 0;
    endtask

    task automatic test_miss_and_spawn();
        hitValid = 0;
        do_clear();
        enable = 1; maxUp = 5; upTime = 5;
        tick_for(2, 1);
        n_total++;
        if (molesUp[2] !== 1'b1 || missPulse !== 1'b1) begin
            n_bad++;
            $display("FAIL miss_and_spawn got hole2=%b miss=%b exp 1/1", molesUp[2], missPulse);
        end
        hitValid = 0;
    endtask

    task automatic test_max_up();
        int peak;
        hitValid = 0;
        do_clear();
        enable = 1; maxUp = 2; upTime = 15;
        peak = 0;
        for (int k = 0; k < 40; k++) begin
            tick = (k % 2 == 0);
            step();
            if (int'(activeCount) > peak) peak = int'(activeCount);
            n_total++;
            if (got_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL max_up_model cyc=%0d got=%b exp=%b", k, got_vec(), exp_vec());
            end
        end
        n_total++;
        if (peak > 2) begin
            n_bad++;
            $display("FAIL max_up_peak got=%0d exp<=2", peak);
        end
        tick = 0;
        do_clear();
        maxUp = 0;
        for (int k = 0; k < 20; k++) begin
            tick = 1; step();
            n_total++;
            if (molesUp !== 5'b00000) begin
                n_bad++;
                $display("FAIL max_up_zero cyc=%0d got=%b exp=00000", k, molesUp);
            end
        end
        tick = 0;
    endtask

    task automatic test_hit_vs_expire();
        hitValid = 0;
        do_clear();
        enable = 1; maxUp = 1; upTime = 0;
        tick_for(1, 0);
        maxUp = 0;
        hitIndex = 3'd2;
        hitValid = 1;
        tick = 1;
        step();
        tick = 0;
        n_total++;
        if (hitPulse !== 1'b1 || escapePulse !== 1'b0 || molesUp[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL hit_vs_expire got hit=%b esc=%b hole1=%b exp 1/0/0", hitPulse, escapePulse, molesUp[1]);
        end
        hitValid = 0;
    endtask

    task automatic test_freeze_clear_reset();
        hitValid = 0;
        do_clear();
        enable = 1; maxUp = 2; upTime = 15;
        tick_for(0, 0);
        tick_for(4, 0);
        n_total++;
        if (molesUp !== 5'b10001) begin
            n_bad++;
            $display("FAIL freeze_setup got=%b exp=10001", molesUp);
        end
        enable = 0;
        hitIndex = 3'd1;
        for (int k = 0; k < 5; k++) begin
            tick = 1;
            hitValid = k[0];
            step();
            n_total++;
            if ({molesUp, hitPulse, missPulse, escapePulse} !== 8'b10001_000) begin
                n_bad++;
                $display("FAIL freeze cyc=%0d got=%b exp=10001000", k, {molesUp, hitPulse, missPulse, escapePulse});
            end
        end
        tick = 0; hitValid = 0;
        enable = 1;
        step();
        clear = 1; tick = 1;
        step();
        clear = 0; tick = 0;
        n_total++;
        if (molesUp !== 5'b00000 || activeCount !== 3'd0) begin
            n_bad++;
            $display("FAIL clear got moles=%b cnt=%0d exp 00000/0", molesUp, activeCount);
        end
        tick_for(1, 0);
        #3;
        reset = 1'b1;
        #1;
        n_total++;
        if (got_vec() !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_mid got=%b exp=%b", got_vec(), 11'd0);
        end
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        enable = 1; maxUp = 5; upTime = 3; tick = 1;
        step();
        tick = 0;
        n_total++;
        if (molesUp !== 5'b00001) begin
            n_bad++;
            $display("FAIL reset_reseed got=%b exp=00001", molesUp);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            enable   = ($urandom_range(0, 9) != 0);
            clear    = ($urandom_range(0, 49) == 0);
            tick     = ($urandom_range(0, 2) == 0);
            hitValid = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) hitIndex = 3'($urandom_range(1, 5));
            else hitIndex = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0) maxUp = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0) upTime = 4'($urandom_range(0, 15));
            step();
            n_total++;
            if (got_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random cyc=%0d got=%b exp=%b", k, got_vec(), exp_vec());
            end
        end
        clear = 0; tick = 0; hitValid = 0;
    endtask

    initial begin
        test_reset();
        test_first_spawn();
        test_escape();
        test_escape_pulse();
        test_hit_hold();
        test_miss_and_spawn();
        test_max_up();
        test_hit_vs_expire();
        test_freeze_clear_reset();
        maxUp = 3; upTime = 4;
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
